// File: rtl/clock_sched.sv
// clock_sched: NCH independent programmable clock dividers with a
// req/ack configuration port. A new scale is staged as "pending" and only
// becomes active on a toggle boundary, so no half-period is ever cut short
// or stretched by a reconfiguration.
module clock_sched #(
    parameter int          NCH           = 4,
    parameter logic [31:0] DEFAULT_SCALE = 32'd50000000
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic [NCH-1:0] ch_en,
    input  logic           cfg_req,
    input  logic [1:0]     cfg_ch,
    input  logic [31:0]    cfg_scale,
    output logic           cfg_ack,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        WAIT_DROP = 2'd2
    } cfg_state_t;

    cfg_state_t state_reg;
    logic       cfg_ack_reg;
    logic       accept;

    // A request is captured only from IDLE, so a held request is taken once.
    assign accept  = (state_reg == IDLE) && cfg_req;
    assign cfg_ack = cfg_ack_reg;

    // Configuration handshake FSM; the ack pulse is a registered output.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg   <= IDLE;
            cfg_ack_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cfg_ack_reg <= 1'b0;
                    if (cfg_req) begin
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    cfg_ack_reg <= 1'b1;
                    state_reg   <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    cfg_ack_reg <= 1'b0;
                    if (!cfg_req) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    cfg_ack_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [31:0] cnt_reg;
            logic [31:0] act_reg;
            logic [31:0] pnd_reg;
            logic [31:0] eff;
            logic        clk_reg;
            logic        tick_reg;
            logic        pend_reg;
            logic        hit;
            logic        toggle;
            logic        apply;
            logic        sel;

            // A zero scale would never match, so it is treated as one.
            assign eff    = (act_reg == 32'd0) ? 32'd1 : act_reg;
            assign hit    = (cnt_reg == eff - 32'd1);
            assign toggle = ch_en[gi] && hit;
            // Pending scale lands on a toggle, or at once when idle.
            assign apply  = pend_reg && (toggle || !ch_en[gi]);
            assign sel    = accept && (int'(cfg_ch) == gi);

            assign clk_out[gi] = clk_reg;
            assign tick[gi]    = tick_reg;
            assign pend[gi]    = pend_reg;

            // Divider counter: wraps and toggles every eff cycles, parks at 0 when disabled.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    cnt_reg  <= 32'd0;
                    clk_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                end else if (!ch_en[gi]) begin
                    cnt_reg  <= 32'd0;
                    clk_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                end else if (hit) begin
                    cnt_reg  <= 32'd0;
                    clk_reg  <= ~clk_reg;
                    tick_reg <= 1'b1;
                end else begin
                    cnt_reg  <= cnt_reg + 32'd1;
                    tick_reg <= 1'b0;
                end
            end

            // Scale staging: a fresh capture wins over clearing pend in the same cycle.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    act_reg  <= DEFAULT_SCALE;
                    pnd_reg  <= DEFAULT_SCALE;
                    pend_reg <= 1'b0;
                end else begin
                    if (apply) begin
                        act_reg <= pnd_reg;
                    end
                    if (sel) begin
                        pnd_reg  <= cfg_scale;
                        pend_reg <= 1'b1;
                    end else if (apply) begin
                        pend_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_clock_sched.sv
// Testbench for clock_sched: scenario tasks push expected tick times and
// clk_out levels into per-channel queues; a negedge monitor records the
// observed ticks, which each task then pops and compares.
module tb_clock_sched;

    localparam int          NCH    = 4;
    localparam logic [31:0] DSCALE = 32'd7;

    logic           CLK = 1'b0;
    logic           RSTN = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic           cfg_req = 1'b0;
    logic [1:0]     cfg_ch = 2'd0;
    logic [31:0]    cfg_scale = 32'd0;
    logic           cfg_ack;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int   tick_q[NCH][$];
    logic val_q[NCH][$];
    int   et[NCH][$];
    logic ev[NCH][$];

    int   ch0_last;
    logic ch0_val;

    clock_sched #(.NCH(NCH), .DEFAULT_SCALE(DSCALE)) dut (
        .CLK(CLK), .RSTN(RSTN), .ch_en(ch_en), .cfg_req(cfg_req),
        .cfg_ch(cfg_ch), .cfg_scale(cfg_scale), .cfg_ack(cfg_ack),
        .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record each observed tick with its cycle number and new clk_out level.
    always @(negedge CLK) begin
        for (int c = 0; c < NCH; c++) begin
            if (tick[c]) begin
                tick_q[c].push_back(cyc);
                val_q[c].push_back(clk_out[c]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        for (int c = 0; c < NCH; c++) begin
            tick_q[c].delete();
            val_q[c].delete();
            et[c].delete();
            ev[c].delete();
        end
    endtask

    // Full handshake; lat = cycles from request to ack (-1 if none), snap = pend at ack.
    task automatic cfg_write(input int ch, input logic [31:0] sc, output int lat,
                             output logic [3:0] snap);
        cfg_ch    = ch[1:0];
        cfg_scale = sc;
        cfg_req   = 1'b1;
        lat  = -1;
        snap = 4'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK);
            #1;
            if (cfg_ack) begin
                lat  = k;
                snap = pend;
                break;
            end
        end
        cfg_req = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        int e;
        int t;
        int te;
        logic v;
        logic ve;
        RSTN = 1'b0; ch_en = '0; cfg_req = 1'b0;
        run(3);
        checks++; if (clk_out !== 4'b0) begin failures++; $display("FAIL rst_clk_out got=%b exp=0000", clk_out); end
        checks++; if (tick !== 4'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0000", tick); end
        checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", cfg_ack); end
        checks++; if (pend !== 4'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0000", pend); end
        RSTN = 1'b1;
        run(1);
        e = cyc;
        clear_mon();
        ch_en = 4'b1000;
        for (int k = 1; k <= 3; k++) begin
            et[3].push_back(e + 7 * k);
            ev[3].push_back(k % 2 == 1);
        end
        run(22);
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (tick_q[c].size() != et[c].size()) begin
                failures++;
                $display("FAIL rst_default_count ch%0d got=%0d exp=%0d", c, tick_q[c].size(), et[c].size());
            end
            while (tick_q[c].size() > 0 && et[c].size() > 0) begin
                t = tick_q[c].pop_front(); v = val_q[c].pop_front();
                te = et[c].pop_front(); ve = ev[c].pop_front();
                checks++;
                if (t !== te || v !== ve) begin
                    failures++;
                    $display("FAIL rst_default_tick ch%0d got t=%0d v=%b exp t=%0d v=%b", c, t, v, te, ve);
                end
            end
        end
        clear_mon();
        ch_en = 4'b0000;
        run(1);
        checks++; if (clk_out[3] !== 1'b0 || tick[3] !== 1'b0) begin failures++; $display("FAIL disable_ch3 got clk=%b tick=%b exp 0 0", clk_out[3], tick[3]); end
        run(10);
        checks++; if (tick_q[3].size() != 0) begin failures++; $display("FAIL disable_hold got=%0d ticks exp=0", tick_q[3].size()); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int lat;
        logic [3:0] snap;
        int e;
        int t;
        int te;
        logic v;
        logic ve;
        cfg_write(0, 32'd4, lat, snap);
        checks++; if (lat !== 2) begin failures++; $display("FAIL basic_ack_lat got=%0d exp=2", lat); end
        checks++; if (cfg_ack !== 1'b0) begin failures++; $display("FAIL basic_ack_width got=%b exp=0", cfg_ack); end
        checks++; if (pend !== 4'b0) begin failures++; $display("FAIL basic_pend_applied got=%b exp=0000", pend); end
        e = cyc;
        clear_mon();
        ch_en = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            et[0].push_back(e + 4 * k);
            ev[0].push_back(k % 2 == 1);
        end
        run(13);
        checks++;
        if (tick_q[0].size() != et[0].size()) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=%0d", tick_q[0].size(), et[0].size());
        end
        while (tick_q[0].size() > 0 && et[0].size() > 0) begin
            t = tick_q[0].pop_front(); v = val_q[0].pop_front();
            te = et[0].pop_front(); ve = ev[0].pop_front();
            checks++;
            if (t !== te || v !== ve) begin
                failures++;
                $display("FAIL basic_tick got t=%0d v=%b exp t=%0d v=%b", t, v, te, ve);
            end
        end
        ch0_last = e + 12;
        ch0_val  = 1'b1;
        $display("test_basic done");
    endtask

    task automatic test_pending();
        int lat;
        logic [3:0] snap;
        int l;
        int t;
        int te;
        logic v;
        logic ve;
        l = ch0_last;
        clear_mon();
        et[0].push_back(l + 4);  ev[0].push_back(1'b0);
        et[0].push_back(l + 14); ev[0].push_back(1'b1);
        et[0].push_back(l + 24); ev[0].push_back(1'b0);
        cfg_write(0, 32'd10, lat, snap);
        checks++; if (lat !== 2) begin failures++; $display("FAIL pend_ack_lat got=%0d exp=2", lat); end
        checks++; if (snap[0] !== 1'b1) begin failures++; $display("FAIL pend_set got=%b exp=1", snap[0]); end
        checks++; if (pend[0] !== 1'b0) begin failures++; $display("FAIL pend_clear_at_toggle got=%b exp=0", pend[0]); end
        run(21);
        checks++;
        if (tick_q[0].size() != et[0].size()) begin
            failures++;
            $display("FAIL pend_count got=%0d exp=%0d", tick_q[0].size(), et[0].size());
        end
        while (tick_q[0].size() > 0 && et[0].size() > 0) begin
            t = tick_q[0].pop_front(); v = val_q[0].pop_front();
            te = et[0].pop_front(); ve = ev[0].pop_front();
            checks++;
            if (t !== te || v !== ve) begin
                failures++;
                $display("FAIL pend_tick got t=%0d v=%b exp t=%0d v=%b", t, v, te, ve);
            end
        end
        ch0_last = l + 24;
        ch0_val  = 1'b0;
        $display("test_pending done");
    endtask

    task automatic test_cfg_hold();
        int acks;
        int lat;
        int lat2;
        logic [3:0] snap;
        cfg_ch = 2'd3; cfg_scale = 32'd5; cfg_req = 1'b1;
        acks = 0; lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK);
            #1;
            if (cfg_ack) begin
                acks++;
                if (lat < 0) lat = k;
            end
        end
        cfg_req = 1'b0;
        checks++; if (acks !== 1) begin failures++; $display("FAIL hold_ack_count got=%0d exp=1", acks); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL hold_ack_lat got=%0d exp=2", lat); end
        run(1);
        cfg_write(3, 32'd5, lat2, snap);
        checks++; if (lat2 !== 2) begin failures++; $display("FAIL hold_reaccept_lat got=%0d exp=2", lat2); end
        checks++; if (pend[3] !== 1'b0) begin failures++; $display("FAIL hold_pend3 got=%b exp=0", pend[3]); end
        $display("test_cfg_hold done");
    endtask

    task automatic test_scale0();
        int lat;
        logic [3:0] snap;
        int e;
        int t;
        int te;
        logic v;
        logic ve;
        cfg_write(2, 32'd0, lat, snap);
        checks++; if (lat !== 2) begin failures++; $display("FAIL s0_ack_lat got=%0d exp=2", lat); end
        checks++; if (pend[2] !== 1'b0) begin failures++; $display("FAIL s0_pend got=%b exp=0", pend[2]); end
        e = cyc;
        clear_mon();
        ch_en = 4'b0101;
        for (int k = 1; k <= 3; k++) begin
            et[2].push_back(e + k);
            ev[2].push_back(k % 2 == 1);
        end
        run(3);
        ch_en = 4'b0001;
        run(1);
        checks++; if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin failures++; $display("FAIL s0_disable got clk=%b tick=%b exp 0 0", clk_out[2], tick[2]); end
        checks++;
        if (tick_q[2].size() != et[2].size()) begin
            failures++;
            $display("FAIL s0_count got=%0d exp=%0d", tick_q[2].size(), et[2].size());
        end
        while (tick_q[2].size() > 0 && et[2].size() > 0) begin
            t = tick_q[2].pop_front(); v = val_q[2].pop_front();
            te = et[2].pop_front(); ve = ev[2].pop_front();
            checks++;
            if (t !== te || v !== ve) begin
                failures++;
                $display("FAIL s0_tick got t=%0d v=%b exp t=%0d v=%b", t, v, te, ve);
            end
        end
        $display("test_scale0 done");
    endtask

    task automatic test_max_scale();
        int lat;
        logic [3:0] snap;
        cfg_write(2, 32'hFFFFFFFF, lat, snap);
        checks++; if (lat !== 2) begin failures++; $display("FAIL max_ack_lat got=%0d exp=2", lat); end
        clear_mon();
        ch_en = 4'b0101;
        run(20);
        checks++; if (tick_q[2].size() != 0) begin failures++; $display("FAIL max_no_tick got=%0d exp=0", tick_q[2].size()); end
        ch_en = 4'b0001;
        run(1);
        $display("test_max_scale done");
    endtask

    task automatic test_back_to_back();
        int l1;
        int l2;
        logic [3:0] s1;
        logic [3:0] s2;
        int e;
        int t;
        int te;
        logic v;
        logic ve;
        e = cyc;
        clear_mon();
        ch_en = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            et[1].push_back(e + 7 + 3 * k);
            ev[1].push_back(k % 2 == 0);
        end
        for (int k = 1; k <= 4; k++) begin
            et[3].push_back(e + 5 * k);
            ev[3].push_back(k % 2 == 1);
        end
        t = ch0_last; v = ch0_val;
        while (t + 10 <= e + 20) begin
            t = t + 10;
            v = ~v;
            if (t >= e) begin
                et[0].push_back(t);
                ev[0].push_back(v);
            end
        end
        ch0_last = t; ch0_val = v;
        cfg_write(1, 32'd6, l1, s1);
        cfg_write(1, 32'd3, l2, s2);
        checks++; if (l1 !== 2 || l2 !== 2) begin failures++; $display("FAIL b2b_ack_lat got=%0d,%0d exp=2,2", l1, l2); end
        checks++; if (s2[1] !== 1'b1) begin failures++; $display("FAIL b2b_pend1 got=%b exp=1", s2[1]); end
        run(15);
        checks++; if (pend !== 4'b0) begin failures++; $display("FAIL b2b_pend_final got=%b exp=0000", pend); end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (tick_q[c].size() != et[c].size()) begin
                failures++;
                $display("FAIL b2b_count ch%0d got=%0d exp=%0d", c, tick_q[c].size(), et[c].size());
            end
            while (tick_q[c].size() > 0 && et[c].size() > 0) begin
                t = tick_q[c].pop_front(); v = val_q[c].pop_front();
                te = et[c].pop_front(); ve = ev[c].pop_front();
                checks++;
                if (t !== te || v !== ve) begin
                    failures++;
                    $display("FAIL b2b_tick ch%0d got t=%0d v=%b exp t=%0d v=%b", c, t, v, te, ve);
                end
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        bit found;
        int lat;
        int e;
        int t;
        int te;
        logic v;
        logic ve;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge CLK);
            #1;
            if (clk_out[0]) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL mid_wait_high got=0 exp=1"); end
        ch_en = 4'b1010;
        run(1);
        checks++; if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin failures++; $display("FAIL mid_drop_ch0 got clk=%b tick=%b exp 0 0", clk_out[0], tick[0]); end
        cfg_ch = 2'd1; cfg_scale = 32'd9; cfg_req = 1'b1;
        lat = -1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK);
            #1;
            if (cfg_ack) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 2) begin failures++; $display("FAIL mid_ack_lat got=%0d exp=2", lat); end
        #1;
        RSTN = 1'b0;
        ch_en = 4'b0000;
        #1;
        checks++; if (clk_out !== 4'b0 || tick !== 4'b0) begin failures++; $display("FAIL mid_rst_out got clk=%b tick=%b exp 0", clk_out, tick); end
        checks++; if (cfg_ack !== 1'b0 || pend !== 4'b0) begin failures++; $display("FAIL mid_rst_cfg got ack=%b pend=%b exp 0", cfg_ack, pend); end
        run(2);
        RSTN = 1'b1;
        lat = -1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK);
            #1;
            if (cfg_ack) begin
                lat = k;
                break;
            end
        end
        cfg_req = 1'b0;
        checks++; if (lat !== 2) begin failures++; $display("FAIL mid_reaccept_lat got=%0d exp=2", lat); end
        run(1);
        e = cyc;
        clear_mon();
        ch_en = 4'b1000;
        et[3].push_back(e + 7);  ev[3].push_back(1'b1);
        et[3].push_back(e + 14); ev[3].push_back(1'b0);
        run(15);
        checks++;
        if (tick_q[3].size() != et[3].size()) begin
            failures++;
            $display("FAIL mid_default_count got=%0d exp=%0d", tick_q[3].size(), et[3].size());
        end
        while (tick_q[3].size() > 0 && et[3].size() > 0) begin
            t = tick_q[3].pop_front(); v = val_q[3].pop_front();
            te = et[3].pop_front(); ve = ev[3].pop_front();
            checks++;
            if (t !== te || v !== ve) begin
                failures++;
                $display("FAIL mid_default_tick got t=%0d v=%b exp t=%0d v=%b", t, v, te, ve);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pending();
        test_cfg_hold();
        test_scale0();
        test_max_scale();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
